bandwidth_check: RTL and testbench
==================================

# bandwidth_check

Receive-side companion to the 512-bit bandwidth stream generator. The block accepts one burst of beats on an AXI4-Stream slave port and checks each beat against the generator's descending-count pattern. It measures the burst duration in clock cycles and reports beat count, error count, first-error index and pass/fail. It sits at the far end of the QSFP loopback path, fed by the link RX stream, and its result registers are read by software.

## Interface
- BURST_LEN, 500: beats expected per burst; the first beat carries this value.
- TIMEOUT, 32'd1_000_000: idle cycles allowed between accepted beats in RECV before the burst is aborted. Must be ≥ 1.

Ports:
- clock  in  1  single clock for all logic
- resetn  in  1  reset, asynchronous and active-low
- ARM  in  1  level; sampled in IDLE or DONE to start a new check
- AXIS_RX_TDATA  in  512  beat data; [31:0] = count, [287:256] = count−1
- AXIS_RX_TVALID  in  1  beat valid
- AXIS_RX_TREADY  out  1  registered ready
- busy  out  1  high in ARMED and RECV
- done  out  1  high in DONE
- pass  out  1  valid while done: 1 when error_count==0, beats_rcvd==BURST_LEN and no timeout
- timed_out  out  1  burst aborted by TIMEOUT
- rx_time  out  64  cycles from first accepted beat to last accepted beat
- beats_rcvd  out  32  beats accepted this burst
- error_count  out  32  beats that failed the check, saturating at 32'hFFFF_FFFF
- first_err_beat  out  32  beats_rcvd index (0-based) of the first failing beat; 32'hFFFF_FFFF if none

## Operation
- The states are IDLE, ARMED, RECV and DONE, held in a 2-bit register.
- IDLE → ARMED on ARM=1.
  - Entering ARMED clears beats_rcvd, error_count and timed_out, sets first_err_beat to all-ones, and loads expected ← BURST_LEN.
- ARMED: waits with no timeout. The first handshake (TVALID & TREADY) latches start_cycle ← cycle_counter, checks that beat, and moves to RECV.
- RECV: every handshake checks the beat and increments beats_rcvd.
  - On the beat that makes beats_rcvd == BURST_LEN: rx_time ← cycle_counter − start_cycle, then go to DONE.
  - A BURST_LEN of 1 completes from ARMED directly to DONE with rx_time = 0.
- Beat check: the beat passes iff TDATA[31:0] == expected and TDATA[287:256] == expected − 1, both 32-bit modulo.
  - On failure, error_count increments (saturating). If this is the first failure, first_err_beat ← the beat's index.
  - After every beat, expected ← expected − 1, wrapping mod 2^32. Resync to received data is never performed.
- Timeout: an idle counter clears on each handshake and increments otherwise while in RECV.
  - When it reaches TIMEOUT, the burst aborts: timed_out ← 1 and rx_time ← cycle_counter − start_cycle, then DONE.
- DONE: results hold. ARM=1 re-enters ARMED and clears results as above.
- cycle_counter: 64-bit free-running counter, cleared only by reset. It wraps mod 2^64 and the rx_time subtraction remains correct across the wrap.

## Timing
- Reset (async assert, synchronous release) sets:
  - state = IDLE
  - AXIS_RX_TREADY = 0, busy = 0, done = 0, pass = 0, timed_out = 0
  - rx_time = 0, beats_rcvd = 0, error_count = 0, first_err_beat = 32'hFFFF_FFFF
  - cycle_counter = 0
- AXIS_RX_TREADY is registered. It is 1 on the cycle after the state register becomes ARMED, and stays 1 through RECV.
  - It drops to 0 on the same edge that enters DONE, so no beat is accepted after the last one.
  - Beats presented in IDLE or DONE are not accepted (backpressure).
- Handshake at edge N updates the counters and state at edge N; the new outputs are visible in cycle N+1.
- done, pass and rx_time become valid on the cycle after the last handshake. pass is combinational from the registered results, gated by done.
- Sustained throughput is one beat per clock, with no bubbles inserted by the block.
- Reset asserted mid-burst aborts immediately. Post-reset state is as listed above; a partial burst leaves no residue.
- ARM held high in DONE re-arms every time DONE is entered. Software must pulse ARM.

## Test plan
- Clean burst: BURST_LEN=500, 500 back-to-back beats with count 500..1 → done=1, pass=1, beats_rcvd=500, error_count=0, rx_time=499, first_err_beat=32'hFFFF_FFFF.
- Throttled source: same data with TVALID low on every third cycle → pass=1, rx_time=748. Check that TREADY is never low during RECV.
- Corrupted beat: beat index 37 carries [287:256]=0 → error_count=1, first_err_beat=37, pass=0, beats_rcvd=500.
- Timeout: TIMEOUT=16, source stops after 100 beats → done after 16 idle cycles, timed_out=1, beats_rcvd=100, pass=0.
- Reset mid-burst: assert resetn=0 asynchronously at beat 250 → all outputs return to their reset values immediately and TREADY=0. A re-ARM followed by a full burst gives pass=1.
- Backpressure when idle: TVALID=1 in IDLE for 10 cycles → TREADY stays 0 and beats_rcvd stays 0. After ARM, the held beat is accepted as beat 0.

Source files
------------

// File: rtl/bandwidth_check.sv
// rtl/bandwidth_check.sv - receive-side checker for the 512-bit descending-count bandwidth stream
//
// Accepts one burst on an AXI4-Stream slave port and checks every beat against
// the generator pattern: [31:0] = count, [287:256] = count-1. The count starts
// at BURST_LEN and falls by one per beat. The block reports the burst duration,
// the beat count, the error count, the first failing beat and pass/fail.
//
// Ports:
//   clock, resetn      clock; asynchronous active-low reset
//   ARM                level, sampled in IDLE/DONE to start a new check
//   AXIS_RX_*          stream slave (TDATA 512b, TVALID, registered TREADY)
//   busy / done        ARMED or RECV / DONE state flags
//   pass               done & no errors & full beat count & no timeout
//   timed_out          burst aborted after TIMEOUT idle cycles in RECV
//   rx_time            cycles from first to last accepted beat (64b)
//   beats_rcvd         beats accepted this burst
//   error_count        failing beats, saturating
//   first_err_beat     0-based index of first failing beat, all-ones if none
module bandwidth_check #(
  parameter int unsigned BURST_LEN = 500,
  parameter logic [31:0] TIMEOUT   = 32'd1_000_000
) (
  input  logic         clock,
  input  logic         resetn,
  input  logic         ARM,
  input  logic [511:0] AXIS_RX_TDATA,
  input  logic         AXIS_RX_TVALID,
  output logic         AXIS_RX_TREADY,
  output logic         busy,
  output logic         done,
  output logic         pass,
  output logic         timed_out,
  output logic [63:0]  rx_time,
  output logic [31:0]  beats_rcvd,
  output logic [31:0]  error_count,
  output logic [31:0]  first_err_beat
);

  localparam logic [31:0] BURST_W  = 32'(BURST_LEN);
  localparam logic [31:0] ALL_ONES = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_RECV  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic        tready_q, tready_d;
  logic        timed_out_q, timed_out_d;
  logic [63:0] rx_time_q, rx_time_d;
  logic [31:0] beats_q, beats_d;
  logic [31:0] err_q, err_d;
  logic [31:0] first_err_q, first_err_d;
  logic [31:0] expected_q, expected_d;
  logic [31:0] idle_q, idle_d;
  logic [63:0] cycle_q;
  logic [63:0] start_q, start_d;

  logic hs;
  logic beat_ok;
  logic do_beat;
  logic last_beat;

  // Only the two count fields are checked; the rest of the beat is don't-care.
  logic unused_tdata;
  assign unused_tdata = ^{AXIS_RX_TDATA[511:288], AXIS_RX_TDATA[255:32]};

  assign hs        = AXIS_RX_TVALID & tready_q;
  assign beat_ok   = (AXIS_RX_TDATA[31:0] == expected_q) &&
                     (AXIS_RX_TDATA[287:256] == (expected_q - 32'd1));
  assign last_beat = ((beats_q + 32'd1) == BURST_W);

  always_comb begin
    state_d     = state_q;
    timed_out_d = timed_out_q;
    rx_time_d   = rx_time_q;
    beats_d     = beats_q;
    err_d       = err_q;
    first_err_d = first_err_q;
    expected_d  = expected_q;
    idle_d      = idle_q;
    start_d     = start_q;
    do_beat     = 1'b0;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (ARM) begin
          state_d     = S_ARMED;
          beats_d     = '0;
          err_d       = '0;
          timed_out_d = 1'b0;
          first_err_d = ALL_ONES;
          expected_d  = BURST_W;
          idle_d      = '0;
        end
      end
      S_ARMED: begin
        // No timeout here: the source may take arbitrarily long to start.
        if (hs) begin
          do_beat = 1'b1;
          start_d = cycle_q;
          idle_d  = '0;
          if (last_beat) begin
            state_d   = S_DONE;
            rx_time_d = '0;
          end else begin
            state_d = S_RECV;
          end
        end
      end
      S_RECV: begin
        if (hs) begin
          do_beat = 1'b1;
          idle_d  = '0;
          if (last_beat) begin
            state_d   = S_DONE;
            rx_time_d = cycle_q - start_q;
          end
        end else if (idle_q == (TIMEOUT - 32'd1)) begin
          // This edge completes the TIMEOUT-th consecutive idle cycle.
          state_d     = S_DONE;
          timed_out_d = 1'b1;
          rx_time_d   = cycle_q - start_q;
        end else begin
          idle_d = idle_q + 32'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (do_beat) begin
      beats_d    = beats_q + 32'd1;
      expected_d = expected_q - 32'd1;
      if (!beat_ok) begin
        if (err_q != ALL_ONES) begin
          err_d = err_q + 32'd1;
        end
        // error_count never returns to zero within a burst, so zero marks
        // "no failure seen yet" without a separate flag.
        if (err_q == '0) begin
          first_err_d = beats_q;
        end
      end
    end

    // Ready rises one cycle after ARMED is entered and falls on the edge that
    // leaves for DONE, so nothing is accepted past the final beat.
    tready_d = ((state_q == S_ARMED) || (state_q == S_RECV)) &&
               ((state_d == S_ARMED) || (state_d == S_RECV));
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q     <= S_IDLE;
      tready_q    <= 1'b0;
      timed_out_q <= 1'b0;
      rx_time_q   <= '0;
      beats_q     <= '0;
      err_q       <= '0;
      first_err_q <= ALL_ONES;
      expected_q  <= BURST_W;
      idle_q      <= '0;
      cycle_q     <= '0;
      start_q     <= '0;
    end else begin
      state_q     <= state_d;
      tready_q    <= tready_d;
      timed_out_q <= timed_out_d;
      rx_time_q   <= rx_time_d;
      beats_q     <= beats_d;
      err_q       <= err_d;
      first_err_q <= first_err_d;
      expected_q  <= expected_d;
      idle_q      <= idle_d;
      cycle_q     <= cycle_q + 64'd1;
      start_q     <= start_d;
    end
  end

  assign AXIS_RX_TREADY = tready_q;
  assign busy           = (state_q == S_ARMED) || (state_q == S_RECV);
  assign done           = (state_q == S_DONE);
  assign pass           = done && (err_q == '0) && (beats_q == BURST_W) && !timed_out_q;
  assign timed_out      = timed_out_q;
  assign rx_time        = rx_time_q;
  assign beats_rcvd     = beats_q;
  assign error_count    = err_q;
  assign first_err_beat = first_err_q;

endmodule

// File: tb/tb_bandwidth_check.sv
// tb/tb_bandwidth_check.sv - scoreboard bench for bandwidth_check
module tb_bandwidth_check;

  localparam int          BL = 500;
  localparam logic [31:0] TO = 32'd16;

  logic         clock = 1'b0;
  logic         resetn = 1'b0;
  logic         ARM = 1'b0;
  logic [511:0] tdata = '0;
  logic         tvalid = 1'b0;
  logic         tready;
  logic         busy, done, pass, timed_out;
  logic [63:0]  rx_time;
  logic [31:0]  beats_rcvd, error_count, first_err_beat;

  bandwidth_check #(.BURST_LEN(BL), .TIMEOUT(TO)) dut (
    .clock          (clock),
    .resetn         (resetn),
    .ARM            (ARM),
    .AXIS_RX_TDATA  (tdata),
    .AXIS_RX_TVALID (tvalid),
    .AXIS_RX_TREADY (tready),
    .busy           (busy),
    .done           (done),
    .pass           (pass),
    .timed_out      (timed_out),
    .rx_time        (rx_time),
    .beats_rcvd     (beats_rcvd),
    .error_count    (error_count),
    .first_err_beat (first_err_beat)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        pass;
    logic        to;
    logic [63:0] rx;
    logic [31:0] beats;
    logic [31:0] errs;
    logic [31:0] first;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   drops   = 0;
  logic done_prev = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic p, input logic t, input logic [63:0] rx,
                          input logic [31:0] beats, input logic [31:0] errs,
                          input logic [31:0] first);
    exp_t x;
    x.pass = p; x.to = t; x.rx = rx; x.beats = beats; x.errs = errs; x.first = first;
    sb.push_back(x);
  endtask

  // Monitor: on every rising edge of done, pop and compare the burst result.
  always @(negedge clock) begin
    if (busy && beats_rcvd != 0 && !done && !tready) drops++;
    if (done && !done_prev) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 64'd1, 64'd0);
      end else begin
        e = sb.pop_front();
        check("pass",           {63'd0, pass},      {63'd0, e.pass});
        check("timed_out",      {63'd0, timed_out}, {63'd0, e.to});
        check("rx_time",        rx_time,            e.rx);
        check("beats_rcvd",     {32'd0, beats_rcvd},     {32'd0, e.beats});
        check("error_count",    {32'd0, error_count},    {32'd0, e.errs});
        check("first_err_beat", {32'd0, first_err_beat}, {32'd0, e.first});
        check("tready_drops",   64'(drops),         64'd0);
      end
      drops = 0;
    end
    done_prev = done;
  end

  function automatic logic [511:0] mk_beat(input logic [31:0] c);
    logic [511:0] d;
    d = {16{32'hDEAD_BEEF}};
    d[31:0]    = c;
    d[287:256] = c - 32'd1;
    return d;
  endfunction

  task automatic check_reset_vals(input string tag);
    check({tag, "_tready"},    {63'd0, tready},    64'd0);
    check({tag, "_busy"},      {63'd0, busy},      64'd0);
    check({tag, "_done"},      {63'd0, done},      64'd0);
    check({tag, "_pass"},      {63'd0, pass},      64'd0);
    check({tag, "_timed_out"}, {63'd0, timed_out}, 64'd0);
    check({tag, "_rx_time"},   rx_time,            64'd0);
    check({tag, "_beats"},     {32'd0, beats_rcvd},     64'd0);
    check({tag, "_errs"},      {32'd0, error_count},    64'd0);
    check({tag, "_first_err"}, {32'd0, first_err_beat}, 64'hFFFF_FFFF);
  endtask

  task automatic arm();
    ARM = 1'b1;
    @(posedge clock); #1;
    ARM = 1'b0;
  endtask

  // Drives beats BL, BL-1, ... until stop_after have been accepted. With
  // throttle set, TVALID is low on every third cycle counted from the first
  // accepted beat.
  task automatic run_burst(input int stop_after, input bit throttle, input int bad_idx);
    int beat = 0;
    int c = 0;
    int guard = 0;
    bit started = 0;
    bit hs;
    while (beat < stop_after && guard < 5000) begin
      tvalid = !(throttle && started && (c % 3 == 2));
      tdata  = mk_beat(32'(BL - beat));
      if (beat == bad_idx) tdata[287:256] = 32'd0;
      @(negedge clock);
      hs = tvalid && tready;
      @(posedge clock); #1;
      if (hs) begin
        beat++;
        started = 1;
      end
      if (started) c++;
      guard++;
    end
    tvalid = 1'b0;
    if (beat < stop_after) check("burst_guard", 64'(beat), 64'(stop_after));
  endtask

  task automatic wait_done(input int bound);
    int k = 0;
    while (!done && k < bound) begin
      @(posedge clock); #1;
      k++;
    end
    if (!done) check("done_wait", 64'd0, 64'd1);
    @(negedge clock);
    @(posedge clock); #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $display("[TB] %0d tests run, %0d failed", n_tests + 1, n_fail + 1);
    $fatal(1);
  end

  initial begin
    #12;
    check_reset_vals("reset");
    @(posedge clock); #1;
    resetn = 1'b1;

    // Backpressure in IDLE: the held beat must not be taken.
    tvalid = 1'b1;
    tdata  = mk_beat(32'(BL));
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      check("idle_tready", {63'd0, tready}, 64'd0);
      check("idle_beats",  {32'd0, beats_rcvd}, 64'd0);
      @(posedge clock); #1;
    end
    push_exp(1'b1, 1'b0, 64'd499, 32'd500, 32'd0, 32'hFFFF_FFFF);
    arm();
    run_burst(BL, 1'b0, -1);
    wait_done(20);

    // Throttled source.
    push_exp(1'b1, 1'b0, 64'd748, 32'd500, 32'd0, 32'hFFFF_FFFF);
    arm();
    run_burst(BL, 1'b1, -1);
    wait_done(20);

    // Corrupted beat 37.
    push_exp(1'b0, 1'b0, 64'd499, 32'd500, 32'd1, 32'd37);
    arm();
    run_burst(BL, 1'b0, 37);
    wait_done(20);

    // Source stalls after 100 beats: abort after 16 idle cycles.
    push_exp(1'b0, 1'b1, 64'd115, 32'd100, 32'd0, 32'hFFFF_FFFF);
    arm();
    run_burst(100, 1'b0, -1);
    wait_done(40);

    // Reset mid-burst, then a full clean burst.
    arm();
    run_burst(250, 1'b0, -1);
    #2;
    resetn = 1'b0;
    #1;
    check_reset_vals("midrst");
    @(posedge clock); #1;
    resetn = 1'b1;
    push_exp(1'b1, 1'b0, 64'd499, 32'd500, 32'd0, 32'hFFFF_FFFF);
    arm();
    run_burst(BL, 1'b0, -1);
    wait_done(20);

    repeat (3) @(posedge clock);
    #1;
    check("scoreboard_drain", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
